// File: rtl/dda_stepper.sv
// DDA grid-traversal engine: walks the map one cell per step from a per-column
// ray setup word and emits one hit (or timeout) record per column.
module dda_stepper #(
  parameter int MAP_W     = 24,
  parameter int MAP_H     = 24,
  parameter int MAX_STEPS = 64,
  parameter int LAST_COL  = 319
) (
  input  logic         pixel_clk_in,
  input  logic         rst_in,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [99:0]  s_tdata,
  output logic [9:0]   map_addr_out,
  input  logic [2:0]   map_data_in,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [38:0]  m_tdata,
  output logic         m_tlast
);

  localparam int CNT_W = $clog2(MAX_STEPS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [5:0] MAP_W6 = 6'(MAP_W);
  localparam logic [5:0] MAP_H6 = 6'(MAP_H);
  localparam logic [9:0] MAP_W10 = 10'(MAP_W);
  localparam logic [8:0] LAST_COL9 = 9'(LAST_COL);

  typedef enum logic [2:0] {IDLE, STEP, FETCH, CHECK, OUTPUT} state_t;

  state_t             state_q, state_d;
  logic [8:0]         hcount_q, hcount_d;
  logic               step_x_q, step_x_d;
  logic               step_y_q, step_y_d;
  logic [4:0]         map_x_q, map_x_d;
  logic [4:0]         map_y_q, map_y_d;
  logic [15:0]        side_x_q, side_x_d;
  logic [15:0]        side_y_q, side_y_d;
  logic [15:0]        delta_x_q, delta_x_d;
  logic [15:0]        delta_y_q, delta_y_d;
  logic               side_q, side_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [9:0]         map_addr_q, map_addr_d;
  logic               s_tready_q, s_tready_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [38:0]        m_tdata_q, m_tdata_d;
  logic               m_tlast_q, m_tlast_d;

  logic [4:0]         map_x_n, map_y_n;
  logic [15:0]        perp;
  logic               out_of_range;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [15:0] clamp_sub(input logic [15:0] a, input logic [15:0] b);
    return (a >= b) ? (a - b) : 16'h0000;
  endfunction

  always_comb begin
    state_d      = state_q;
    hcount_d     = hcount_q;
    step_x_d     = step_x_q;
    step_y_d     = step_y_q;
    map_x_d      = map_x_q;
    map_y_d      = map_y_q;
    side_x_d     = side_x_q;
    side_y_d     = side_y_q;
    delta_x_d    = delta_x_q;
    delta_y_d    = delta_y_q;
    side_d       = side_q;
    step_cnt_d   = step_cnt_q;
    map_addr_d   = map_addr_q;
    s_tready_d   = s_tready_q;
    m_tvalid_d   = m_tvalid_q;
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = m_tlast_q;
    map_x_n      = map_x_q;
    map_y_n      = map_y_q;
    perp         = side_q ? clamp_sub(side_y_q, delta_y_q) : clamp_sub(side_x_q, delta_x_q);
    // A -1 step from cell 0 wraps to 31, which this comparison also catches.
    out_of_range = ({1'b0, map_x_q} >= MAP_W6) || ({1'b0, map_y_q} >= MAP_H6);

    case (state_q)
      IDLE: begin
        if (s_tvalid && s_tready_q) begin
          hcount_d   = s_tdata[99:91];
          step_x_d   = s_tdata[90];
          step_y_d   = s_tdata[89];
          map_x_d    = s_tdata[88:84];
          map_y_d    = s_tdata[83:79];
          side_x_d   = s_tdata[78:63];
          side_y_d   = s_tdata[62:47];
          delta_x_d  = s_tdata[46:31];
          delta_y_d  = s_tdata[30:15];
          step_cnt_d = '0;
          s_tready_d = 1'b0;
          state_d    = STEP;
        end
      end
      STEP: begin
        if (side_x_q < side_y_q) begin
          side_x_d = sat_add(side_x_q, delta_x_q);
          map_x_n  = step_x_q ? (map_x_q + 5'd1) : (map_x_q - 5'd1);
          side_d   = 1'b0;
        end else begin
          side_y_d = sat_add(side_y_q, delta_y_q);
          map_y_n  = step_y_q ? (map_y_q + 5'd1) : (map_y_q - 5'd1);
          side_d   = 1'b1;
        end
        map_x_d    = map_x_n;
        map_y_d    = map_y_n;
        map_addr_d = 10'(map_y_n) * MAP_W10 + 10'(map_x_n);
        step_cnt_d = step_cnt_q + 1'b1;
        state_d    = FETCH;
      end
      FETCH: state_d = CHECK;
      CHECK: begin
        if (out_of_range || (map_data_in != 3'd0) || (step_cnt_q == MAX_CNT)) begin
          if (out_of_range)
            m_tdata_d = {hcount_q, side_q, 3'd1, perp, map_x_q, map_y_q};
          else if (map_data_in != 3'd0)
            m_tdata_d = {hcount_q, side_q, map_data_in, perp, map_x_q, map_y_q};
          else
            m_tdata_d = {hcount_q, side_q, 3'd0, 16'hFFFF, map_x_q, map_y_q};
          m_tlast_d  = (hcount_q == LAST_COL9);
          m_tvalid_d = 1'b1;
          state_d    = OUTPUT;
        end else begin
          state_d = STEP;
        end
      end
      OUTPUT: begin
        if (m_tready) begin
          m_tvalid_d = 1'b0;
          s_tready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      hcount_q   <= '0;
      step_x_q   <= 1'b0;
      step_y_q   <= 1'b0;
      map_x_q    <= '0;
      map_y_q    <= '0;
      side_x_q   <= '0;
      side_y_q   <= '0;
      delta_x_q  <= '0;
      delta_y_q  <= '0;
      side_q     <= 1'b0;
      step_cnt_q <= '0;
      map_addr_q <= '0;
      s_tready_q <= 1'b1;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcount_q   <= hcount_d;
      step_x_q   <= step_x_d;
      step_y_q   <= step_y_d;
      map_x_q    <= map_x_d;
      map_y_q    <= map_y_d;
      side_x_q   <= side_x_d;
      side_y_q   <= side_y_d;
      delta_x_q  <= delta_x_d;
      delta_y_q  <= delta_y_d;
      side_q     <= side_d;
      step_cnt_q <= step_cnt_d;
      map_addr_q <= map_addr_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  assign s_tready     = s_tready_q;
  assign map_addr_out = map_addr_q;
  assign m_tvalid     = m_tvalid_q;
  assign m_tdata      = m_tdata_q;
  assign m_tlast      = m_tlast_q;

endmodule

// File: tb/tb_dda_stepper.sv
// Directed bench for dda_stepper: table of rays with hand-computed hit records,
// plus backpressure/tlast and mid-ray reset sequences.
module tb_dda_stepper;

  logic         clk;
  logic         rst;
  logic         s_tvalid;
  logic         s_tready;
  logic [99:0]  s_tdata;
  logic [9:0]   map_addr;
  logic [2:0]   map_data;
  logic         m_tvalid;
  logic         m_tready;
  logic [38:0]  m_tdata;
  logic         m_tlast;

  logic [2:0]   rom [0:1023];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0]  hcount;
    logic        step_x;
    logic        step_y;
    logic [4:0]  map_x;
    logic [4:0]  map_y;
    logic [15:0] sx;
    logic [15:0] sy;
    logic [15:0] dx;
    logic [15:0] dy;
    int          n;
    logic        side;
    logic [2:0]  wall;
    logic [15:0] perp;
    logic [4:0]  ex;
    logic [4:0]  ey;
    logic        tlast;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs [NVEC];
  vec_t bp_vec;

  dda_stepper #(
    .MAP_W(24), .MAP_H(24), .MAX_STEPS(4), .LAST_COL(319)
  ) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tdata      (s_tdata),
    .map_addr_out (map_addr),
    .map_data_in  (map_data),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous map ROM: data appears one edge after the address register.
  always @(posedge clk) map_data <= rom[map_addr];

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepts one setup word and waits (bounded) for m_tvalid; returns edges after accept.
  task automatic applyStimulus(input vec_t v, output int lat);
    @(negedge clk);
    checkValue("s_tready idle", 64'(s_tready), 64'd1);
    s_tvalid = 1'b1;
    s_tdata  = {v.hcount, v.step_x, v.step_y, v.map_x, v.map_y, v.sx, v.sy, v.dx, v.dy, 15'd0};
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    checkValue("s_tready busy", 64'(s_tready), 64'd0);
    lat = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_tvalid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic checkOutput(input vec_t v, input int lat);
    checkValue("latency", 64'(lat), 64'(3 * v.n));
    checkValue("m_tdata", 64'(m_tdata), 64'({v.hcount, v.side, v.wall, v.perp, v.ex, v.ey}));
    checkValue("m_tlast", 64'(m_tlast), 64'(v.tlast));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int stale;

    vecs[0] = '{9'd10,  1'b1, 1'b1, 5'd5,  5'd5,  16'h0080, 16'h0200, 16'h0100, 16'h0100,
                1, 1'b0, 3'd2, 16'h0080, 5'd6,  5'd5,  1'b0};
    vecs[1] = '{9'd20,  1'b1, 1'b1, 5'd3,  5'd3,  16'h0100, 16'h0100, 16'h0100, 16'h0100,
                2, 1'b0, 3'd3, 16'h0100, 5'd4,  5'd4,  1'b0};
    vecs[2] = '{9'd30,  1'b0, 1'b1, 5'd0,  5'd8,  16'h0010, 16'h0200, 16'h0100, 16'h0100,
                1, 1'b0, 3'd1, 16'h0010, 5'd31, 5'd8,  1'b0};
    vecs[3] = '{9'd40,  1'b1, 1'b1, 5'd12, 5'd12, 16'h0008, 16'h0010, 16'h0010, 16'h0010,
                4, 1'b1, 3'd0, 16'hFFFF, 5'd14, 5'd14, 1'b0};
    vecs[4] = '{9'd50,  1'b1, 1'b1, 5'd9,  5'd9,  16'hFF00, 16'hFFFF, 16'h0200, 16'h0100,
                1, 1'b0, 3'd4, 16'hFDFF, 5'd10, 5'd9,  1'b0};
    vecs[5] = '{9'd100, 1'b1, 1'b0, 5'd2,  5'd10, 16'h0300, 16'h0040, 16'h0100, 16'h0080,
                1, 1'b1, 3'd6, 16'h0040, 5'd2,  5'd9,  1'b0};
    bp_vec  = '{9'd319, 1'b1, 1'b1, 5'd5,  5'd5,  16'h0080, 16'h0200, 16'h0100, 16'h0100,
                1, 1'b0, 3'd2, 16'h0080, 5'd6,  5'd5,  1'b1};

    for (int i = 0; i < 1024; i++) rom[i] = 3'd0;
    rom[5*24+6]  = 3'd2;
    rom[4*24+4]  = 3'd3;
    rom[8*24+31] = 3'd5;
    rom[9*24+10] = 3'd4;
    rom[9*24+2]  = 3'd6;

    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkValue("reset m_tvalid", 64'(m_tvalid), 64'd0);
    checkValue("reset m_tdata", 64'(m_tdata), 64'd0);
    checkValue("reset m_tlast", 64'(m_tlast), 64'd0);
    checkValue("reset map_addr", 64'(map_addr), 64'd0);
    checkValue("reset s_tready", 64'(s_tready), 64'd1);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput(vecs[i], lat);
      @(posedge clk);
      @(negedge clk);
      checkValue("post m_tvalid", 64'(m_tvalid), 64'd0);
      checkValue("post s_tready", 64'(s_tready), 64'd1);
    end

    $display("[TB] backpressure with tlast");
    m_tready = 1'b0;
    applyStimulus(bp_vec, lat);
    checkOutput(bp_vec, lat);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkValue("bp hold", 64'({m_tvalid, s_tready, m_tlast, m_tdata}),
                 64'({1'b1, 1'b0, 1'b1, bp_vec.hcount, bp_vec.side, bp_vec.wall,
                      bp_vec.perp, bp_vec.ex, bp_vec.ey}));
    end
    m_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkValue("bp release m_tvalid", 64'(m_tvalid), 64'd0);
    checkValue("bp release s_tready", 64'(s_tready), 64'd1);

    $display("[TB] reset mid-ray");
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = {vecs[0].hcount, vecs[0].step_x, vecs[0].step_y, vecs[0].map_x, vecs[0].map_y,
                vecs[0].sx, vecs[0].sy, vecs[0].dx, vecs[0].dy, 15'd0};
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkValue("mid-ray map_addr", 64'(map_addr), 64'(5*24+6));
    rst = 1'b1;
    #1;
    checkValue("async m_tvalid", 64'(m_tvalid), 64'd0);
    checkValue("async m_tdata", 64'(m_tdata), 64'd0);
    checkValue("async map_addr", 64'(map_addr), 64'd0);
    checkValue("async s_tready", 64'(s_tready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m_tvalid) stale++;
    end
    checkValue("no stale record", 64'(stale), 64'd0);
    applyStimulus(vecs[1], lat);
    checkOutput(vecs[1], lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dda_stepper.md
# dda_stepper

Grid-traversal (DDA) engine of the raycaster. Consumes one per-column ray setup word from the DDA-in FIFO, walks the map grid cell by cell against the map ROM until a wall is found, and emits one hit record per column into the DDA-out FIFO for the flattening stage. Processes one column at a time, with AXI-stream style handshakes on both sides.

## Interface
Parameters:
- MAP_W, 24, map width in cells (map x range 0..MAP_W-1)
- MAP_H, 24, map height in cells
- MAX_STEPS, 64, step budget per ray before timeout
- LAST_COL, 319, hcount value that marks end of frame (tlast)

Ports:
- pixel_clk_in  in  1  pixel clock; the only clock
- rst_in  in  1  asynchronous, active-high reset
- s_tvalid  in  1  setup word valid (DDA-in FIFO receiver_axis_tvalid)
- s_tready  out  1  engine ready for a setup word
- s_tdata  in  100  {hcount[8:0], stepX, stepY, mapX[4:0], mapY[4:0], sideDistX[15:0], sideDistY[15:0], deltaDistX[15:0], deltaDistY[15:0]}, MSB first; distances unsigned Q8.8; step bit 1 = +1, 0 = −1
- map_addr_out  out  10  map ROM address = mapY*MAP_W + mapX
- map_data_in  in  3  map ROM cell value, valid 1 cycle after address is registered; 0 = empty
- m_tvalid  out  1  hit record valid
- m_tready  in  1  DDA-out FIFO ready
- m_tdata  out  39  {hcount[8:0], side, wall_type[2:0], perp_dist[15:0], mapX[4:0], mapY[4:0]}
- m_tlast  out  1  high with the record whose hcount == LAST_COL

## Operation
- States: IDLE, STEP, FETCH, CHECK, OUTPUT.
- IDLE: s_tready=1. On s_tvalid&s_tready capture all fields, clear step counter, go STEP.
- STEP: if sideDistX < sideDistY: sideDistX += deltaDistX, mapX += step, side=0; else (including tie): sideDistY += deltaDistY, mapY += step, side=1. Additions saturate at 16'hFFFF. Step counter +1. Register map_addr_out from new coords. Go FETCH.
- FETCH: wait for ROM. Go CHECK.
- CHECK, priority order:
  - new coord out of range (step −1 from 0 wraps to 31, or ≥ MAP_W/MAP_H) → hit, wall_type=1, no ROM dependence;
  - map_data_in ≠ 0 → hit, wall_type=map_data_in;
  - step counter == MAX_STEPS → timeout record: wall_type=0, perp_dist=16'hFFFF;
  - else → STEP.
  - Hit/timeout → OUTPUT.
- perp_dist on hit: side 0 → sideDistX − deltaDistX; side 1 → sideDistY − deltaDistY (post-step values; result ≥ 0 by construction, clamp to 0 if negative).
- Start cell is never tested; first check is after one step.
- OUTPUT: m_tvalid=1, m_tdata/m_tlast held stable until m_tready; on m_tvalid&m_tready go IDLE.
- s_tready is 0 in every state except IDLE.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE; m_tvalid=0, m_tdata=0, m_tlast=0, map_addr_out=0, counters/regs 0. s_tready=1 from first cycle after deassert.
- Reset mid-ray: in-flight ray discarded, no record emitted.
- 3 cycles per step. Setup accepted on edge E0; a ray hitting on step n has m_tvalid high from cycle E0+3n+1.
- Throughput with m_tready=1: one ray per 3n+2 cycles (OUTPUT and IDLE one cycle each); no back-to-back accept in the OUTPUT cycle.
- m_tready low: holds OUTPUT indefinitely, no data change, s_tready stays 0.
- s_tvalid low in IDLE: stays IDLE, map_addr_out holds last value.

## Test plan
- Single step hit: mapX=5,mapY=5,stepX=1, sideDistX=0x0080, sideDistY=0x0200, deltaDistX=0x0100, deltaDistY=0x0100, ROM(6,5)=2, hcount=10 → m_tvalid at cycle 4, side=0, wall_type=2, perp_dist=0x0080, mapX=6,mapY=5, tlast=0.
- Tie and multi-step: sideDistX=sideDistY=0x0100, deltas 0x0100, steps +1 from (3,3), wall only at (4,4) → steps Y,X,… record side per last step, mapX=4,mapY=4, valid at cycle 7.
- Boundary: mapX=0, stepX=0, sideDistX=0x0010 < sideDistY, empty map → hit with wall_type=1, mapX=31, after 1 step.
- Timeout: all-empty ROM, MAX_STEPS=4 forced in-range (deltas small, map center) → wall_type=0, perp_dist=0xFFFF after 4 steps, cycle 13.
- Backpressure and tlast: hcount=319, m_tready low 20 cycles → m_tvalid/m_tdata stable, s_tready=0, m_tlast=1; release → IDLE next cycle, s_tready=1.
- Reset mid-ray: assert rst_in in FETCH → m_tvalid=0 immediately; after release, new ray processed correctly, no stale record.
